priority_resolver_n: RTL and testbench

PRIORITY_RESOLVER_N -- requirements
Module: priority_resolver_n

---
 rtl/priority_resolver_n.sv | 157 +++++++++++++++
 tb/tb_priority_resolver_n.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_n.sv
// priority_resolver_n: 8259-style interrupt priority resolver with rotating
// priority, in-service tracking, special mask mode and auto-EOI.
// Optional macro PR_ROTATE_EN enables priority rotation (rotating EOI
// commands, set-priority and rotate-on-AEOI). Without it the lowest-priority
// channel stays fixed at NUM_IRQ-1.
//
// Strobe semantics: inta_valid and eoi_valid are single-cycle strobes with no
// back-pressure (no ready); each strobe is consumed on the clock edge where it
// is high. ack_valid is a single-cycle result strobe one cycle after each
// inta_valid, carrying ack_id/ack_spurious.
module priority_resolver_n #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               special_mask_mode,
  input  logic               auto_eoi,
  input  logic               inta_valid,
  input  logic               eoi_valid,
  input  logic [2:0]         eoi_cmd,
  input  logic [ID_W-1:0]    eoi_level,
  output logic               int_out,
  output logic [ID_W-1:0]    int_id,
  output logic               ack_valid,
  output logic [ID_W-1:0]    ack_id,
  output logic               ack_spurious,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    priority_base
);

  // Returns {found, index} of the first set bit of vec scanning cyclically
  // upward from start (start itself is the highest priority).
  function automatic logic [ID_W:0] first_from(input logic [NUM_IRQ-1:0] vec,
                                               input logic [ID_W-1:0]    start);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = start + ID_W'(k);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic               rotate_aeoi;
  logic [NUM_IRQ-1:0] isr_nxt;
  logic [ID_W-1:0]    base_nxt;
  logic               rot_nxt;
  logic [ID_W-1:0]    cur_start;
  logic [ID_W:0]      isr_top;
`ifdef PR_ROTATE_EN
  logic               eoi_base_upd;
`endif

  assign cur_start = priority_base + ID_W'(1);
  assign isr_top   = first_from(isr, cur_start);

  // Next in-service / priority state: EOI clear first, then INTA set.
  always_comb begin
    isr_nxt  = isr;
    base_nxt = priority_base;
    rot_nxt  = rotate_aeoi;
`ifdef PR_ROTATE_EN
    eoi_base_upd = 1'b0;
`else
    rot_nxt = 1'b0;
`endif
    if (eoi_valid) begin
      case (eoi_cmd)
        3'b001: if (isr_top[ID_W]) isr_nxt[isr_top[ID_W-1:0]] = 1'b0;
        3'b011: isr_nxt[eoi_level] = 1'b0;
`ifdef PR_ROTATE_EN
        3'b101: begin
          if (isr_top[ID_W]) begin
            isr_nxt[isr_top[ID_W-1:0]] = 1'b0;
            base_nxt     = isr_top[ID_W-1:0];
            eoi_base_upd = 1'b1;
          end
        end
        3'b111: begin
          isr_nxt[eoi_level] = 1'b0;
          base_nxt     = eoi_level;
          eoi_base_upd = 1'b1;
        end
        3'b110: begin
          base_nxt     = eoi_level;
          eoi_base_upd = 1'b1;
        end
        3'b100: rot_nxt = 1'b1;
        3'b000: rot_nxt = 1'b0;
`else
        3'b101: if (isr_top[ID_W]) isr_nxt[isr_top[ID_W-1:0]] = 1'b0;
        3'b111: isr_nxt[eoi_level] = 1'b0;
`endif
        default: ;
      endcase
    end
    if (inta_valid && int_out) begin
      if (!auto_eoi) begin
        isr_nxt[int_id] = 1'b1;
      end
`ifdef PR_ROTATE_EN
      else if (rotate_aeoi && !eoi_base_upd) begin
        base_nxt = int_id;
      end
`endif
    end
  end

  logic [NUM_IRQ-1:0] mreq;
  logic [NUM_IRQ-1:0] eff_isr;
  logic [ID_W-1:0]    nxt_start;
  logic [ID_W:0]      cand;
  logic [ID_W:0]      eff_top;
  logic [ID_W-1:0]    cand_rank;
  logic [ID_W-1:0]    top_rank;
  logic               win;

  // Winner for the next cycle, judged against the next-cycle isr and base.
  always_comb begin
    mreq      = irq_req & ~irq_mask;
    eff_isr   = special_mask_mode ? (isr_nxt & ~irq_mask) : isr_nxt;
    nxt_start = base_nxt + ID_W'(1);
    cand      = first_from(mreq, nxt_start);
    eff_top   = first_from(eff_isr, nxt_start);
    cand_rank = cand[ID_W-1:0] - nxt_start;
    top_rank  = eff_top[ID_W-1:0] - nxt_start;
    win       = cand[ID_W] && (!eff_top[ID_W] || (cand_rank < top_rank));
  end

  // State registers and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      isr           <= '0;
      priority_base <= ID_W'(NUM_IRQ - 1);
      rotate_aeoi   <= 1'b0;
      int_out       <= 1'b0;
      int_id        <= '0;
      ack_valid     <= 1'b0;
      ack_id        <= '0;
      ack_spurious  <= 1'b0;
    end else begin
      isr           <= isr_nxt;
      priority_base <= base_nxt;
      rotate_aeoi   <= rot_nxt;
      int_out       <= win;
      int_id        <= win ? cand[ID_W-1:0] : '0;
      ack_valid     <= inta_valid;
      ack_spurious  <= inta_valid & ~int_out;
      if (inta_valid) ack_id <= int_out ? int_id : ID_W'(NUM_IRQ - 1);
    end
  end

endmodule

// File: tb/tb_priority_resolver_n.sv
// Directed bench for priority_resolver_n: an 8-channel instance for most of
// the behaviour and a 16-channel instance for the same-cycle EOI/INTA case.
module tb_priority_resolver_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // 8-channel instance signals
  logic        reset_n = 1'b0;
  logic [7:0]  irq_req = '0, irq_mask = '0;
  logic        smm = 1'b0, auto_eoi = 1'b0, inta_valid = 1'b0, eoi_valid = 1'b0;
  logic [2:0]  eoi_cmd = '0;
  logic [2:0]  eoi_level = '0;
  logic        int_out, ack_valid, ack_spurious;
  logic [2:0]  int_id, ack_id, priority_base;
  logic [7:0]  isr;

  // 16-channel instance signals
  logic [15:0] b_irq_req = '0;
  logic        b_inta_valid = 1'b0, b_eoi_valid = 1'b0;
  logic [2:0]  b_eoi_cmd = '0;
  logic [3:0]  b_eoi_level = '0;
  logic        b_int_out, b_ack_valid, b_ack_spurious;
  logic [3:0]  b_int_id, b_ack_id, b_priority_base;
  logic [15:0] b_isr;

  priority_resolver_n #(.NUM_IRQ(8), .ID_W(3)) dut8 (
    .clock(clock), .reset_n(reset_n), .irq_req(irq_req), .irq_mask(irq_mask),
    .special_mask_mode(smm), .auto_eoi(auto_eoi), .inta_valid(inta_valid),
    .eoi_valid(eoi_valid), .eoi_cmd(eoi_cmd), .eoi_level(eoi_level),
    .int_out(int_out), .int_id(int_id), .ack_valid(ack_valid), .ack_id(ack_id),
    .ack_spurious(ack_spurious), .isr(isr), .priority_base(priority_base)
  );

  priority_resolver_n #(.NUM_IRQ(16), .ID_W(4)) dut16 (
    .clock(clock), .reset_n(reset_n), .irq_req(b_irq_req), .irq_mask(16'h0000),
    .special_mask_mode(1'b0), .auto_eoi(1'b0), .inta_valid(b_inta_valid),
    .eoi_valid(b_eoi_valid), .eoi_cmd(b_eoi_cmd), .eoi_level(b_eoi_level),
    .int_out(b_int_out), .int_id(b_int_id), .ack_valid(b_ack_valid), .ack_id(b_ack_id),
    .ack_spurious(b_ack_spurious), .isr(b_isr), .priority_base(b_priority_base)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic inta_pulse();
    inta_valid = 1'b1;
    tick();
    inta_valid = 1'b0;
  endtask

  task automatic eoi(input logic [2:0] cmd, input logic [2:0] lvl);
    eoi_valid = 1'b1;
    eoi_cmd   = cmd;
    eoi_level = lvl;
    tick();
    eoi_valid = 1'b0;
  endtask

`ifdef PR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  initial begin
    // Reset values
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_int_out", int_out, 0);
    chk("rst_int_id", int_id, 0);
    chk("rst_ack_valid", ack_valid, 0);
    chk("rst_ack_id", ack_id, 0);
    chk("rst_ack_spur", ack_spurious, 0);
    chk("rst_isr", isr, 0);
    chk("rst_base", priority_base, 7);
    chk("rst_b_base", b_priority_base, 15);
    reset_n = 1'b1;

    // Basic request and acknowledge
    irq_req = 8'h24; tick();
    chk("req24_int_out", int_out, 1);
    chk("req24_int_id", int_id, 2);
    inta_pulse();
    chk("ack2_valid", ack_valid, 1);
    chk("ack2_id", ack_id, 2);
    chk("ack2_spur", ack_spurious, 0);
    chk("ack2_isr", isr, 8'h04);
    chk("ack2_no_represent", int_out, 0);
    tick();
    chk("ack2_one_cycle", ack_valid, 0);

    // Nesting against in-service channel 2
    irq_req = 8'h20; tick();
    chk("nest_lower_blocked", int_out, 0);
    irq_req = 8'h21; tick();
    chk("nest_higher_out", int_out, 1);
    chk("nest_higher_id", int_id, 0);
    inta_pulse();
    chk("nest_isr", isr, 8'h05);
    chk("nest_ack_id", ack_id, 0);
    irq_req = 8'h00;
    eoi(3'b011, 3'd2);
    chk("spec_eoi_isr", isr, 8'h01);

    // Rotating EOI on channel 0
    eoi(3'b101, 3'd0);
    chk("reoi_isr", isr, 0);
    chk("reoi_base", priority_base, ROT ? 0 : 7);
    irq_req = 8'h81; tick();
    chk("rot_int_out", int_out, 1);
    chk("rot_int_id", int_id, ROT ? 7 : 0);
    inta_pulse();
    chk("rot_ack_isr", isr, ROT ? 8'h80 : 8'h01);

    // Withdrawn request then spurious acknowledge
    irq_req = 8'h00; tick();
    chk("withdraw_int_out", int_out, 0);
    inta_pulse();
    chk("spur_valid", ack_valid, 1);
    chk("spur_flag", ack_spurious, 1);
    chk("spur_id", ack_id, 7);
    chk("spur_isr_kept", isr, ROT ? 8'h80 : 8'h01);
    eoi(3'b001, 3'd0);
    chk("ns_eoi_isr", isr, 0);
    eoi(3'b110, 3'd7);
    chk("setpri_base7", priority_base, 7);

    // Special mask mode
    irq_req = 8'h01; tick();
    inta_pulse();
    chk("smm_setup_isr", isr, 8'h01);
    irq_mask = 8'h01; irq_req = 8'h08; smm = 1'b1; tick();
    chk("smm1_int_out", int_out, 1);
    chk("smm1_int_id", int_id, 3);
    smm = 1'b0; tick();
    chk("smm0_int_out", int_out, 0);
    irq_mask = 8'h00; irq_req = 8'h00;
    eoi(3'b001, 3'd0);
    chk("smm_clear_isr", isr, 0);

    // Rotating EOI with empty isr changes nothing
    eoi(3'b101, 3'd0);
    chk("reoi_empty_base", priority_base, 7);
    chk("reoi_empty_isr", isr, 0);

    // Auto-EOI, with and without rotation
    auto_eoi = 1'b1; irq_req = 8'h02; tick();
    chk("aeoi_int_id", int_id, 1);
    inta_pulse();
    chk("aeoi_isr", isr, 0);
    chk("aeoi_ack_id", ack_id, 1);
    chk("aeoi_still_out", int_out, 1);
    eoi(3'b100, 3'd0);
    inta_pulse();
    chk("aeoi_rot_base", priority_base, ROT ? 1 : 7);
    eoi_valid = 1'b1; eoi_cmd = 3'b110; eoi_level = 3'd5; inta_valid = 1'b1;
    tick();
    eoi_valid = 1'b0; inta_valid = 1'b0;
    chk("eoi_base_wins", priority_base, ROT ? 5 : 7);
    eoi(3'b000, 3'd0);
    eoi(3'b110, 3'd7);
    auto_eoi = 1'b0; irq_req = 8'h00;
    chk("aeoi_restore_base", priority_base, 7);

    // Reset mid-service discards coincident strobes
    irq_req = 8'h04; tick();
    inta_pulse();
    chk("mid_isr", isr, 8'h04);
    reset_n = 1'b0; inta_valid = 1'b1; eoi_valid = 1'b1; eoi_cmd = 3'b110; eoi_level = 3'd3;
    tick();
    inta_valid = 1'b0; eoi_valid = 1'b0;
    chk("midrst_isr", isr, 0);
    chk("midrst_ack_valid", ack_valid, 0);
    chk("midrst_base", priority_base, 7);
    chk("midrst_int_out", int_out, 0);
    reset_n = 1'b1; irq_req = 8'h00;
    tick();

    // 16 channels: same-cycle specific EOI and INTA on channel 2
    b_irq_req = 16'h0004; tick();
    chk("b_int_id", b_int_id, 2);
    b_inta_valid = 1'b1; tick(); b_inta_valid = 1'b0;
    chk("b_isr_set", b_isr, 16'h0004);
    chk("b_blocked", b_int_out, 0);
    b_eoi_valid = 1'b1; b_eoi_cmd = 3'b011; b_eoi_level = 4'd2; tick(); b_eoi_valid = 1'b0;
    chk("b_isr_clear", b_isr, 16'h0000);
    chk("b_represent", b_int_out, 1);
    b_eoi_valid = 1'b1; b_inta_valid = 1'b1; tick();
    b_eoi_valid = 1'b0; b_inta_valid = 1'b0;
    chk("b_set_wins", b_isr, 16'h0004);
    chk("b_ack_id", b_ack_id, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
